// File: rtl/sign_bitmap_reader.sv
// Streams a 1-bpp image from a registered-read ROM as RGB565 pixels over valid/ready.
// A 2-entry buffer plus credit-based issue absorbs the ROM latency and downstream stalls.
module sign_bitmap_reader #(
    parameter int ADDR_WIDTH  = 17,
    parameter int IMG_W       = 480,
    parameter int IMG_H       = 272,
    parameter int COLOR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [COLOR_WIDTH-1:0] fg_color_i,
    input  logic [COLOR_WIDTH-1:0] bg_color_i,
    output logic [ADDR_WIDTH-1:0]  rom_addr_o,
    input  logic                   rom_data_i,
    output logic [COLOR_WIDTH-1:0] pix_data_o,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic                   pix_eol_o,
    output logic                   pix_last_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int EW   = COLOR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [XW-1:0]         LAST_X    = XW'(IMG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [XW-1:0]          x_q, x_d;
    logic [COLOR_WIDTH-1:0] fg_q, fg_d, bg_q, bg_d;
    logic                   fl_valid_q, fl_eol_q, fl_last_q;
    logic [EW-1:0]          mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;
    logic                   done_q;

    logic          pop, push, issue, head_last;
    logic [2:0]    occ;
    logic [EW-1:0] head;

    // Buffer entry layout: {colour, eol, last}
    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[0];
    assign pop       = (count_q != 2'd0) && pix_ready_i;
    assign push      = fl_valid_q;
    assign occ       = {1'b0, count_q} + {2'b00, fl_valid_q};
    // Issue only if the returning word is guaranteed a free slot next cycle
    assign issue     = (state_q == S_FETCH) && (occ < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    fg_d    = fg_color_i;
                    bg_d    = bg_color_i;
                    addr_d  = '0;
                    x_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        x_d    = (x_q == LAST_X) ? '0 : x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            fl_valid_q <= 1'b0;
            fl_eol_q   <= 1'b0;
            fl_last_q  <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            fl_valid_q <= issue;
            fl_eol_q   <= (x_q == LAST_X);
            fl_last_q  <= (addr_q == LAST_ADDR);
            if (push) mem_q[wr_ptr_q] <= {rom_data_i ? fg_q : bg_q, fl_eol_q, fl_last_q};
            wr_ptr_q   <= wr_ptr_q ^ push;
            rd_ptr_q   <= rd_ptr_q ^ pop;
            count_q    <= count_q + {1'b0, push} - {1'b0, pop};
            done_q     <= pop && head_last;
        end
    end

    assign rom_addr_o  = addr_q;
    assign pix_valid_o = (count_q != 2'd0);
    assign pix_data_o  = pix_valid_o ? head[EW-1:2] : '0;
    assign pix_eol_o   = pix_valid_o & head[1];
    assign pix_last_o  = pix_valid_o & head[0];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
endmodule

// File: tb/tb_sign_bitmap_reader.sv
// Bench for sign_bitmap_reader: a 4x3 image (table + corner sequences) and a 48x27
// image with random content, both checked against a pixel-index reference model.
module tb_sign_bitmap_reader;
    localparam int NA = 12;
    localparam int WB = 48;
    localparam int NB = 48 * 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pixel i of a w-wide, n-pixel frame -> {colour, eol, last}
    function automatic logic [17:0] exp_pix(input logic b, input logic [15:0] fg,
                                            input logic [15:0] bg, input int i,
                                            input int w, input int n);
        return {b ? fg : bg, (i % w) == w - 1, i == n - 1};
    endfunction

    // ---------------- instance A: 4x3 ----------------
    logic        start_a = 0, ready_a = 1, rom_data_a = 0;
    logic [15:0] fg_a = 0, bg_a = 0;
    logic [3:0]  rom_addr_a;
    logic [15:0] pix_data_a;
    logic        valid_a, eol_a, last_a, busy_a, done_a;
    logic        img_a [0:NA-1];

    sign_bitmap_reader #(.ADDR_WIDTH(4), .IMG_W(4), .IMG_H(3), .COLOR_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .fg_color_i(fg_a), .bg_color_i(bg_a),
        .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a), .pix_data_o(pix_data_a),
        .pix_valid_o(valid_a), .pix_ready_i(ready_a), .pix_eol_o(eol_a),
        .pix_last_o(last_a), .busy_o(busy_a), .done_o(done_a));

    always @(posedge clk) rom_data_a <= img_a[rom_addr_a];

    // ---------------- instance B: 48x27 ----------------
    logic        start_b = 0, ready_b = 1, rom_data_b = 0;
    logic [15:0] fg_b = 0, bg_b = 0;
    logic [10:0] rom_addr_b;
    logic [15:0] pix_data_b;
    logic        valid_b, eol_b, last_b, busy_b, done_b;
    logic        img_b [0:NB-1];

    sign_bitmap_reader #(.ADDR_WIDTH(11), .IMG_W(48), .IMG_H(27), .COLOR_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .fg_color_i(fg_b), .bg_color_i(bg_b),
        .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b), .pix_data_o(pix_data_b),
        .pix_valid_o(valid_b), .pix_ready_i(ready_b), .pix_eol_o(eol_b),
        .pix_last_o(last_b), .busy_o(busy_b), .done_o(done_b));

    always @(posedge clk) rom_data_b <= img_b[rom_addr_b];

    // ---------------- monitors ----------------
    logic [17:0] got_a[$], got_b[$];
    int          got_a_cyc[$], got_b_cyc[$];
    logic        stall_a = 0, stall_b = 0;
    logic [17:0] held_a, held_b;
    int          max_addr_b = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_a) begin
                chk("a_stall_valid", valid_a, 1);
                chk("a_stall_hold", {pix_data_a, eol_a, last_a}, held_a);
            end
            chk("a_addr_bound", rom_addr_a > 4'd11, 0);
            if (busy_a) chk("a_credit", (int'(rom_addr_a) - got_a.size()) <= 2, 1);
            if (valid_a && ready_a) begin
                got_a.push_back({pix_data_a, eol_a, last_a});
                got_a_cyc.push_back(cyc + 1);
            end
            stall_a = valid_a && !ready_a;
            held_a  = {pix_data_a, eol_a, last_a};

            if (stall_b) chk("b_stall_hold", {valid_b, pix_data_b, eol_b, last_b}, {1'b1, held_b});
            if (int'(rom_addr_b) > max_addr_b) max_addr_b = int'(rom_addr_b);
            if (busy_b) chk("b_credit", (int'(rom_addr_b) - got_b.size()) <= 2, 1);
            if (valid_b && ready_b) begin
                got_b.push_back({pix_data_b, eol_b, last_b});
                got_b_cyc.push_back(cyc + 1);
            end
            stall_b = valid_b && !ready_b;
            held_b  = {pix_data_b, eol_b, last_b};
        end else begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    // mode 0: ready=1, 1: random ready, 2: ready 0 until 10 cycles after first valid,
    // 3: ready=1 with colour change and start pulse mid-frame
    task automatic run_a(input int mode, input logic [15:0] fg, input logic [15:0] bg,
                         output int t0, output int tdone);
        int first_v;
        got_a.delete();
        got_a_cyc.delete();
        @(posedge clk); #1;
        fg_a = fg; bg_a = bg; start_a = 1'b1;
        ready_a = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        t0 = cyc;
        tdone = -1;
        first_v = -1;
        for (int i = 0; i < 400; i++) begin
            if (done_a) begin
                tdone = cyc;
                break;
            end
            case (mode)
                0: begin
                    if (cyc == t0 + 1) chk("a_first_valid_early", valid_a, 0);
                    if (cyc == t0 + 2) chk("a_first_valid", valid_a, 1);
                end
                1: ready_a = 1'($urandom_range(0, 1));
                2: begin
                    if (first_v < 0 && valid_a) first_v = cyc;
                    ready_a = (first_v >= 0) && (cyc >= first_v + 10);
                    if (!ready_a && first_v >= 0) begin
                        chk("a_stall_reads", rom_addr_a <= 4'd2, 1);
                        chk("a_stall_pix0", {pix_data_a, eol_a, last_a},
                            exp_pix(img_a[0], fg, bg, 0, 4, NA));
                    end
                end
                3: begin
                    chk("a_busy_hold", busy_a, 1);
                    if (cyc == t0 + 5) begin
                        start_a = 1'b1; fg_a = 16'h07E0; bg_a = 16'h07E0;
                    end else begin
                        start_a = 1'b0;
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        if (tdone < 0) chk("a_done_timeout", 0, 1);
    endtask

    task automatic check_frame_a(input string name, input logic [15:0] fg, input logic [15:0] bg);
        chk({name, "_count"}, got_a.size(), NA);
        for (int i = 0; i < NA && i < got_a.size(); i++)
            chk({name, "_pix"}, got_a[i], exp_pix(img_a[i], fg, bg, i, 4, NA));
    endtask

    task automatic run_b(input logic rand_ready);
        int t0, tdone;
        logic [15:0] fg, bg;
        fg = 16'($urandom); bg = 16'($urandom);
        got_b.delete();
        got_b_cyc.delete();
        max_addr_b = 0;
        @(posedge clk); #1;
        fg_b = fg; bg_b = bg; start_b = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        fg_b = 16'($urandom); bg_b = 16'($urandom);
        t0 = cyc;
        tdone = -1;
        for (int i = 0; i < 8000; i++) begin
            if (done_b) begin
                tdone = cyc;
                break;
            end
            if (rand_ready) ready_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ready_b = 1'b1;
        if (tdone < 0) chk("b_done_timeout", 0, 1);
        chk("b_count", got_b.size(), NB);
        chk("b_max_addr", max_addr_b, NB - 1);
        for (int i = 0; i < NB && i < got_b.size(); i++)
            chk("b_pix", got_b[i], exp_pix(img_b[i], fg, bg, i, WB, NB));
        if (!rand_ready && got_b.size() == NB) begin
            chk("b_last_time", got_b_cyc[NB-1], t0 + NB + 2);
            chk("b_done_time", tdone, t0 + NB + 2);
        end
    endtask

    typedef struct {
        logic        bit_in;
        logic [15:0] data;
        logic        eol;
        logic        last;
    } vec_t;
    vec_t tbl [NA];

    initial begin
        int t0, tdone;
        logic [11:0] pat;

        // Image 0xA5F read MSB first: pixel i is bit 11-i
        tbl[0]  = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h001F, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h001F, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h001F, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h001F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'hF800, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'hF800, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 16'hF800, 1'b1, 1'b1};
        pat = 12'hA5F;
        for (int i = 0; i < NA; i++) img_a[i] = pat[11-i];
        for (int i = 0; i < NB; i++) img_b[i] = 1'($urandom_range(0, 1));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs_a", {rom_addr_a, pix_data_a, valid_a, eol_a, last_a, busy_a, done_a}, 0);
        chk("rst_outputs_b", {rom_addr_b, pix_data_b, valid_b, eol_b, last_b, busy_b, done_b}, 0);
        rst = 1'b0;

        // Ready tied high: table, timing, done
        run_a(0, 16'hF800, 16'h001F, t0, tdone);
        chk("a0_count", got_a.size(), NA);
        for (int i = 0; i < NA && i < got_a.size(); i++) begin
            chk("a0_tbl_pix", got_a[i], {tbl[i].data, tbl[i].eol, tbl[i].last});
            chk("a0_pix_time", got_a_cyc[i], t0 + 3 + i);
        end
        chk("a0_done_time", tdone, t0 + NA + 2);
        chk("a0_busy_after", busy_a, 0);

        // start coincident with done is accepted: begin the next frame right away
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("a_start_on_done", busy_a, 1);
        for (int i = 0; i < 40 && !done_a; i++) begin
            @(posedge clk); #1;
        end
        chk("a_restart_done", done_a, 1);
        @(posedge clk); #1;

        // Random ready, several frames
        for (int k = 0; k < 4; k++) begin
            run_a(1, 16'hF800, 16'h001F, t0, tdone);
            check_frame_a("a_rand", 16'hF800, 16'h001F);
        end

        // Held ready low then released: sustained 1 pixel/clk afterwards
        run_a(2, 16'hF800, 16'h001F, t0, tdone);
        check_frame_a("a_stall", 16'hF800, 16'h001F);
        for (int i = 1; i < got_a_cyc.size(); i++)
            chk("a_resume_rate", got_a_cyc[i], got_a_cyc[i-1] + 1);

        // Mid-frame colour change and start pulse are ignored
        run_a(3, 16'hF800, 16'h001F, t0, tdone);
        check_frame_a("a_midchg", 16'hF800, 16'h001F);

        // Reset while pixel 5 is presented
        got_a.delete();
        got_a_cyc.delete();
        @(posedge clk); #1;
        fg_a = 16'hF800; bg_a = 16'h001F; start_a = 1'b1; ready_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 40 && got_a.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("a_pre_rst_count", got_a.size(), 5);
        chk("a_pre_rst_pix5", {valid_a, pix_data_a, eol_a, last_a},
            {1'b1, exp_pix(img_a[5], 16'hF800, 16'h001F, 5, 4, NA)});
        for (int i = 0; i < 5 && i < got_a.size(); i++)
            chk("a_pre_rst_pix", got_a[i], exp_pix(img_a[i], 16'hF800, 16'h001F, i, 4, NA));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("a_mid_rst_outputs", {rom_addr_a, pix_data_a, valid_a, eol_a, last_a, busy_a, done_a}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("a_post_rst_idle", {valid_a, busy_a}, 0);
        run_a(0, 16'h1234, 16'hABCD, t0, tdone);
        check_frame_a("a_post_rst", 16'h1234, 16'hABCD);

        // Larger image, random content
        run_b(1'b0);
        run_b(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
